// File: rtl/hsid_x_obi_mem_wr.sv
// OBI manager write engine: streams valid/ready words to consecutive word addresses
// and reports completion only once every write response has returned.
package hsid_x_obi_inf_pkg;
    localparam int unsigned HSID_WORD_WIDTH       = 32;
    localparam int unsigned HSID_MEM_ACCESS_WIDTH = 16;

    typedef struct packed {
        logic [HSID_WORD_WIDTH-1:0]   addr;
        logic                         we;
        logic [HSID_WORD_WIDTH/8-1:0] be;
        logic [HSID_WORD_WIDTH-1:0]   wdata;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [HSID_WORD_WIDTH-1:0] rdata;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_resp_t;
endpackage

module hsid_x_obi_mem_wr #(
    parameter int unsigned WORD_WIDTH       = hsid_x_obi_inf_pkg::HSID_WORD_WIDTH,
    parameter int unsigned MEM_ACCESS_WIDTH = hsid_x_obi_inf_pkg::HSID_MEM_ACCESS_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    output hsid_x_obi_inf_pkg::obi_req_t      obi_req,
    input  hsid_x_obi_inf_pkg::obi_resp_t     obi_rsp,
    input  logic [WORD_WIDTH-1:0]             initial_addr,
    input  logic [MEM_ACCESS_WIDTH-1:0]       limit,
    input  logic [WORD_WIDTH-1:0]             data_in,
    input  logic                              data_in_valid,
    output logic                              data_in_ready,
    input  logic                              start,
    input  logic                              clear,
    output logic                              idle,
    output logic                              ready,
    output logic                              done
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] ABORT = 3'd4;

    localparam logic [WORD_WIDTH-1:0] ADDR_STEP = WORD_WIDTH'(WORD_WIDTH / 8);

    logic [2:0]                  state_q, state_d;
    logic [WORD_WIDTH-1:0]       next_addr_q, next_addr_d;
    logic [WORD_WIDTH-1:0]       req_addr_q, req_addr_d;
    logic [WORD_WIDTH-1:0]       wdata_q, wdata_d;
    logic                        req_q, req_d;
    logic [MEM_ACCESS_WIDTH-1:0] limit_q, limit_d;
    logic [MEM_ACCESS_WIDTH-1:0] issued_q, issued_d;
    logic [MEM_ACCESS_WIDTH-1:0] granted_q, granted_d;
    logic [MEM_ACCESS_WIDTH-1:0] acked_q, acked_d;

    logic                        grant;
    logic                        accept;
    logic                        rsp_ok;
    logic [MEM_ACCESS_WIDTH-1:0] outstanding_now;

    assign grant         = req_q && obi_rsp.gnt;
    assign data_in_ready = (state_q == WRITE) && (issued_q < limit_q) && (!req_q || obi_rsp.gnt);
    assign accept        = data_in_valid && data_in_ready;

    // A response may arrive in the same cycle as the grant it answers, so count that grant too.
    assign outstanding_now = granted_q + MEM_ACCESS_WIDTH'(grant) - acked_q;
    assign rsp_ok          = obi_rsp.rvalid && (outstanding_now != '0);

    assign idle  = (state_q == IDLE);
    assign ready = (state_q == WRITE) || (state_q == DRAIN);
    assign done  = (state_q == DONE);

    always_comb begin
        obi_req         = '0;
        obi_req.req     = req_q;
        obi_req.a.addr  = req_addr_q;
        obi_req.a.we    = req_q;
        obi_req.a.be    = req_q ? '1 : '0;
        obi_req.a.wdata = wdata_q;
    end

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        req_addr_d  = req_addr_q;
        wdata_d     = wdata_q;
        req_d       = req_q;
        limit_d     = limit_q;
        issued_d    = issued_q + MEM_ACCESS_WIDTH'(accept);
        granted_d   = granted_q + MEM_ACCESS_WIDTH'(grant);
        acked_d     = acked_q + MEM_ACCESS_WIDTH'(rsp_ok);

        if (accept) begin
            req_d       = 1'b1;
            req_addr_d  = next_addr_q;
            wdata_d     = data_in;
            next_addr_d = next_addr_q + ADDR_STEP;
        end else if (grant) begin
            req_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start && !clear) begin
                    next_addr_d = initial_addr;
                    limit_d     = limit;
                    issued_d    = '0;
                    granted_d   = '0;
                    acked_d     = '0;
                    state_d     = (limit == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (clear) begin
                    state_d = ABORT;
                end else if ((issued_q == limit_q) && grant) begin
                    state_d = (acked_d == limit_q) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (clear) begin
                    state_d = ABORT;
                end else if (acked_d == limit_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = clear ? ABORT : IDLE;
            end
            ABORT: begin
                if (!req_d && (granted_d == acked_d)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            next_addr_q <= '0;
            req_addr_q  <= '0;
            wdata_q     <= '0;
            req_q       <= 1'b0;
            limit_q     <= '0;
            issued_q    <= '0;
            granted_q   <= '0;
            acked_q     <= '0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            req_addr_q  <= req_addr_d;
            wdata_q     <= wdata_d;
            req_q       <= req_d;
            limit_q     <= limit_d;
            issued_q    <= issued_d;
            granted_q   <= granted_d;
            acked_q     <= acked_d;
        end
    end
endmodule

// File: tb/tb_hsid_x_obi_mem_wr.sv
// Scoreboard bench for hsid_x_obi_mem_wr: accepted words are queued with their expected
// address and compared when the engine's request is granted.
module tb_hsid_x_obi_mem_wr;
    import hsid_x_obi_inf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    obi_req_t    obi_req;
    obi_resp_t   obi_rsp;
    logic        gnt, rvalid;
    logic [31:0] initial_addr;
    logic [15:0] limit;
    logic [31:0] data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic        start, clear;
    logic        idle, ready, done;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb_q[$];
    int tb_out;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        obi_rsp         = '0;
        obi_rsp.gnt     = gnt;
        obi_rsp.rvalid  = rvalid;
        obi_rsp.r.rdata = 32'hDEAD_BEEF;
    end

    hsid_x_obi_mem_wr #(.WORD_WIDTH(32), .MEM_ACCESS_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .obi_req(obi_req), .obi_rsp(obi_rsp),
        .initial_addr(initial_addr), .limit(limit), .data_in(data_in),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .start(start), .clear(clear), .idle(idle), .ready(ready), .done(done)
    );

    task automatic drive(input bit g, input bit rv, input bit v, input logic [31:0] d);
        @(negedge clk);
        start = 1'b0;
        gnt = g; rvalid = rv; data_in_valid = v; data_in = d;
        #1;
    endtask

    task automatic do_start(input logic [31:0] a, input logic [15:0] l);
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b0; data_in_valid = 1'b0; clear = 1'b0;
        initial_addr = a; limit = l; start = 1'b1;
        sb_q.delete();
        tb_out = 0;
    endtask

    // Full transfer against a randomly stalling subordinate; probabilities in percent.
    task automatic run_transfer(input string name, input logic [31:0] a, input int lim,
                                input logic [31:0] dbase, input int gp, input int rp, input int vp);
        int k = 0, grants = 0, resps = 0, last_rv = -10, n = 0;
        bit prev_pend = 0, got_done = 0, g, rv, v;
        logic [31:0] prev_addr = '0, prev_wdata = '0, pa;
        logic [63:0] exp;
        do_start(a, 16'(lim));
        while (!got_done && n < 2000) begin
            n++;
            g  = ($urandom_range(99) < gp);
            rv = (tb_out > 0) && ($urandom_range(99) < rp);
            v  = ($urandom_range(99) < vp);
            drive(g, rv, v, dbase + k);
            if (prev_pend) begin
                checks++;
                if (obi_req.req !== 1'b1 || obi_req.a.addr !== prev_addr || obi_req.a.wdata !== prev_wdata) begin
                    errors++;
                    $display("FAIL %s hold: req=%b addr=%h wdata=%h, required req=1 addr=%h wdata=%h",
                             name, obi_req.req, obi_req.a.addr, obi_req.a.wdata, prev_addr, prev_wdata);
                end
            end
            if (obi_req.req && !g) begin
                checks++;
                if (data_in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s ready_while_stalled: data_in_ready=%b required 0", name, data_in_ready);
                end
            end
            if (done === 1'b1) begin
                got_done = 1;
                checks++;
                if (grants != lim || resps != lim || sb_q.size() != 0 || cyc != last_rv + 1) begin
                    errors++;
                    $display("FAIL %s done_cond: grants=%0d resps=%0d left=%0d gap=%0d, required %0d %0d 0 1",
                             name, grants, resps, sb_q.size(), cyc - last_rv, lim, lim);
                end
            end else begin
                checks++;
                if (ready !== 1'b1 || idle !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_status: ready=%b idle=%b required 1 0", name, ready, idle);
                end
            end
            if (obi_req.req && g) begin
                grants++;
                pa = obi_req.a.addr;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hX;
                checks++;
                if ({pa, obi_req.a.wdata} !== exp || obi_req.a.we !== 1'b1 || obi_req.a.be !== 4'hF) begin
                    errors++;
                    $display("FAIL %s write: addr=%h wdata=%h we=%b be=%h, required addr=%h wdata=%h we=1 be=f",
                             name, pa, obi_req.a.wdata, obi_req.a.we, obi_req.a.be, exp[63:32], exp[31:0]);
                end
                tb_out++;
            end
            if (rv) begin
                tb_out--; resps++; last_rv = cyc;
            end
            if (v && data_in_ready) begin
                sb_q.push_back({a + 32'(4 * k), dbase + k});
                k++;
            end
            prev_pend  = obi_req.req && !g;
            prev_addr  = obi_req.a.addr;
            prev_wdata = obi_req.a.wdata;
        end
        if (!got_done) begin
            errors++;
            $display("FAIL %s timeout: done never seen, required done within 2000 cycles", name);
        end
        drive(0, 0, 0, '0);
        checks++;
        if (idle !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: idle=%b done=%b required 1 0", name, idle, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; gnt = 0; rvalid = 0; data_in_valid = 0; data_in = '0;
        start = 0; clear = 0; initial_addr = '0; limit = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (idle !== 1 || ready !== 0 || done !== 0 || data_in_ready !== 0 || obi_req !== '0) begin
            errors++;
            $display("FAIL reset_state: idle=%b ready=%b done=%b dir=%b req=%h, required 1 0 0 0 0",
                     idle, ready, done, data_in_ready, obi_req);
        end
    endtask

    task automatic test_back_to_back();
        run_transfer("b2b", 32'h1000, 8, 32'hA0, 100, 100, 100);
    endtask

    task automatic test_addr_wrap();
        run_transfer("wrap", 32'hFFFF_FFF8, 4, 32'h5000, 100, 100, 100);
    endtask

    task automatic test_stall();
        run_transfer("stall", 32'h2000, 20, 32'h100, 45, 40, 100);
    endtask

    task automatic test_bursty();
        run_transfer("bursty", 32'h3000, 10, 32'h700, 80, 60, 50);
    endtask

    task automatic test_clear_abort();
        int grants = 0, k = 0, n = 0;
        bit seen_done = 0, rv;
        logic [31:0] held_addr, held_wdata;
        logic [63:0] exp;
        do_start(32'h4000, 16'd16);
        while (grants < 5 && n < 100) begin
            n++;
            rv = (tb_out > 0);
            drive(1, rv, 1, 32'hC00 + k);
            if (obi_req.req) begin
                grants++; tb_out++;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hX;
                checks++;
                if ({obi_req.a.addr, obi_req.a.wdata} !== exp) begin
                    errors++;
                    $display("FAIL clear pre_write: got %h/%h required %h/%h",
                             obi_req.a.addr, obi_req.a.wdata, exp[63:32], exp[31:0]);
                end
            end
            if (rv) tb_out--;
            if (data_in_ready) begin
                sb_q.push_back({32'h4000 + 32'(4 * k), 32'hC00 + k}); k++;
            end
        end
        // Clear while the sixth request is pending and not granted.
        clear = 1'b1;
        drive(0, 0, 1, 32'hC00 + k);
        clear = 1'b0;
        held_addr = obi_req.a.addr; held_wdata = obi_req.a.wdata;
        checks++;
        if (obi_req.req !== 1 || data_in_ready !== 0) begin
            errors++;
            $display("FAIL clear pending_req: req=%b dir=%b required 1 0", obi_req.req, data_in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 32'hC00 + k);
            checks++;
            if (obi_req.req !== 1 || obi_req.a.addr !== held_addr || obi_req.a.wdata !== held_wdata ||
                data_in_ready !== 0 || idle !== 0 || ready !== 0 || done !== 0) begin
                errors++;
                $display("FAIL abort_hold: req=%b addr=%h dir=%b idle=%b ready=%b done=%b required 1 %h 0 0 0 0",
                         obi_req.req, obi_req.a.addr, data_in_ready, idle, ready, done, held_addr);
            end
        end
        drive(1, 0, 1, 32'hC00 + k);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hX;
        checks++;
        if ({obi_req.a.addr, obi_req.a.wdata} !== exp || obi_req.req !== 1) begin
            errors++;
            $display("FAIL abort_grant: got %h/%h required %h/%h",
                     obi_req.a.addr, obi_req.a.wdata, exp[63:32], exp[31:0]);
        end
        tb_out++;
        n = 0;
        while (tb_out > 0 && n < 50) begin
            n++;
            drive(0, 1, 1, 32'hC00 + k);
            tb_out--;
            if (done) seen_done = 1;
            checks++;
            if (idle !== 0 || data_in_ready !== 0 || obi_req.req !== 0) begin
                errors++;
                $display("FAIL abort_drain: idle=%b dir=%b req=%b required 0 0 0", idle, data_in_ready, obi_req.req);
            end
        end
        drive(0, 0, 1, 32'hC00 + k);
        if (done) seen_done = 1;
        checks++;
        if (idle !== 1 || seen_done || data_in_ready !== 0) begin
            errors++;
            $display("FAIL abort_end: idle=%b done_seen=%b dir=%b required 1 0 0", idle, seen_done, data_in_ready);
        end
    endtask

    task automatic test_limit_zero();
        do_start(32'h8000, 16'd0);
        drive(1, 0, 1, 32'h1);
        checks++;
        if (done !== 1 || obi_req.req !== 0 || idle !== 0 || data_in_ready !== 0) begin
            errors++;
            $display("FAIL limit0_done: done=%b req=%b idle=%b dir=%b required 1 0 0 0",
                     done, obi_req.req, idle, data_in_ready);
        end
        drive(1, 0, 1, 32'h1);
        checks++;
        if (done !== 0 || idle !== 1 || obi_req.req !== 0) begin
            errors++;
            $display("FAIL limit0_idle: done=%b idle=%b req=%b required 0 1 0", done, idle, obi_req.req);
        end
    endtask

    task automatic test_reset_mid_write();
        do_start(32'h9000, 16'd8);
        drive(0, 0, 1, 32'h55);
        drive(0, 0, 1, 32'h56);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, '0);
        rst = 1'b0;
        checks++;
        if (idle !== 1 || ready !== 0 || obi_req !== '0 || data_in_ready !== 0) begin
            errors++;
            $display("FAIL reset_mid: idle=%b ready=%b req=%h dir=%b required 1 0 0 0",
                     idle, ready, obi_req, data_in_ready);
        end
        run_transfer("post_reset", 32'hA000, 2, 32'h10, 100, 100, 100);
    endtask

    task automatic test_clear_start_idle();
        @(negedge clk);
        initial_addr = 32'hB000; limit = 16'd3; start = 1'b1; clear = 1'b1;
        drive(0, 0, 0, '0);
        clear = 1'b0;
        checks++;
        if (idle !== 1 || ready !== 0 || obi_req.req !== 0) begin
            errors++;
            $display("FAIL clear_start_idle: idle=%b ready=%b req=%b required 1 0 0", idle, ready, obi_req.req);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_addr_wrap();
        test_stall();
        test_bursty();
        test_clear_abort();
        test_limit_zero();
        test_reset_mid_write();
        test_clear_start_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
